// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency RAM port between fetch, data and loader (loader > data > fetch).
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch outrank data after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              ld_req,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall,
    output logic [1:0]        owner
);
    logic              r_lock;
    logic [1:0]        r_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_force;
    logic              w_cpu_ok;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    logic [SW-1:0] r_starve;
    // Saturates so a fetch starved through a long loader lock is still forced once it ends.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_starve <= '0;
        else if (!if_req || if_gnt) r_starve <= '0;
        else if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
    assign w_force = (r_starve == SW'(STARVE_LIMIT)) && if_req;
`else
    assign w_force = STARVE_LIMIT < 0;
`endif

    // Grants are gated by rst so nothing leaks onto the port while reset is held.
    always_comb begin
        w_cpu_ok  = !rst && !ld_req && !r_lock;
        ld_gnt    = !rst && ld_req;
        d_gnt     = w_cpu_ok && d_req && !w_force;
        if_gnt    = w_cpu_ok && if_req && (!d_req || w_force);
        owner     = ld_gnt ? 2'd3 : d_gnt ? 2'd2 : if_gnt ? 2'd1 : 2'd0;
        mem_addr  = ld_gnt ? ld_addr : d_gnt ? d_addr : if_gnt ? if_addr : r_addr;
        mem_wdata = ld_gnt ? ld_wdata : d_gnt ? d_wdata : r_wdata;
        mem_wren  = ld_gnt || (d_gnt && d_we);
        cpu_stall = !rst && (r_lock || (if_req && !if_gnt) || (d_req && !d_gnt));
        if_rvalid = r_pend == 2'd1;
        d_rvalid  = r_pend == 2'd2;
        if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
        d_rdata   = d_rvalid ? mem_rdata : r_d_rdata;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_lock     <= 1'b0;
            r_pend     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_lock  <= ld_lock && (r_lock || ld_gnt);
            r_pend  <= mem_wren ? 2'd0 : owner;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            if (if_rvalid) r_if_rdata <= mem_rdata;
            if (d_rvalid) r_d_rdata <= mem_rdata;
        end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM port (altsyncram style, 1-cycle read latency) between three requesters:
  - CPU instruction fetch
  - CPU data access (LDR/STR)
  - Program loader, which writes images at runtime
- Grants at most one access per cycle and routes read data back to the originating requester.
- Sits between `integrated_cpu`'s datapath/controller and the unified memory macro.

Parameters:
- ADDR_W, 11, word address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before a forced fetch grant (only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- ld_req  in  1  loader write request
- ld_lock  in  1  loader holds the port
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader granted this cycle
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address
- cpu_stall  out  1  CPU requester pending and not granted, or port locked
- owner  out  2  current-cycle grant: 0 none, 1 fetch, 2 data, 3 loader

Behaviour:
- **Reset (rst high, async):**
  - All gnt, rvalid, mem_wren, cpu_stall outputs are 0; owner = 0; mem_addr/mem_wdata = 0.
  - Pending-read register cleared; lock flag cleared; starve counter = 0.
- **Grant timing:** combinational from requests and registered state, same cycle as the request.
  - Requester holds req/addr/wdata stable until it sees gnt.
  - Each gnt is exactly one access; back-to-back grants to the same requester are allowed.
- **Priority (fixed):** loader > data > fetch.
- **Lock:** set when ld_gnt and ld_lock are both high; clears on the first cycle ld_lock is low.
  - While the lock is set, if_gnt and d_gnt are 0 even with ld_req low.
  - cpu_stall = 1 for the whole lock interval.
- **Memory drive:**
  - The grantee's address goes to mem_addr.
  - mem_wren = 1 for a loader grant, or for a data grant with d_we = 1.
  - With no grant: mem_wren = 0 and mem_addr holds its last value.
- **Read return:**
  - On a read grant, register the owner id.
  - The next cycle pulses that requester's rvalid for 1 cycle; its rdata = mem_rdata.
  - The non-owner's rdata holds its last captured value.
  - Writes never produce rvalid.
- **Read throughput:** a read may be granted every cycle. Pending-owner tracking is a 1-deep pipeline, so at most one return is outstanding per cycle.
- **Simultaneous loader + CPU request:** loader wins; the CPU requester sees no gnt and cpu_stall = 1.
- **Reset asserted mid-read:** the pending return is dropped; no rvalid after rst deasserts.
- **Reads-during-write:** a read granted in the cycle after a write to the same address returns the new data.

Optional Feature:
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- **When defined:**
  - A counter increments each cycle if_req is high and if_gnt is low; it resets to 0 on if_gnt or when if_req is low.
  - When the counter equals STARVE_LIMIT, fetch outranks data for that cycle only. The loader and the lock still win.
- **When undefined:** strict fixed priority, no counter logic.

Test Plan:
- Reset: drive if_req = 1, if_addr = 5 during rst high → all gnt/rvalid = 0, owner = 0. After release → if_gnt = 1 that cycle; if_rvalid = 1 next cycle with if_rdata = mem[5].
- Priority: if_req, d_req (load addr 10), ld_req (addr 3, data 0xAA) in the same cycle → ld_gnt, mem_wren = 1, mem_addr = 3. Next cycle d_gnt (fetch still denied, cpu_stall = 1). Cycle after, if_gnt.
- Store then load: d_we = 1, d_addr = 10, d_wdata = 11; then a load from 10 → d_rvalid one cycle after the second grant, d_rdata = 11; if_rvalid stays 0.
- Lock: ld_lock = 1 with 4 loader writes at addrs 0..3, then ld_req low for 2 cycles with lock high → no if_gnt/d_gnt, cpu_stall = 1. Drop ld_lock → if_gnt the following cycle.
- Reset mid-read: grant a fetch at addr 7, assert rst in the next cycle before the clock edge → if_rvalid never pulses.
- Starvation (macro defined, STARVE_LIMIT = 4): d_req and if_req held continuously → if_gnt in the 5th cycle. Macro undefined → if_gnt never while d_req stays high.
